// File: rtl/jk_latch_if.sv
// Bundle of per-cell JK controls and registered state for jk_latch.
// The driver of en/J/K uses master; the latch array uses slave.
interface jk_latch_if #(
    parameter int unsigned WIDTH = 1
);
    logic             en;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qn;

    modport master (
        output en,
        output J,
        output K,
        input  Q,
        input  Qn
    );

    modport slave (
        input  en,
        input  J,
        input  K,
        output Q,
        output Qn
    );
endinterface

// File: rtl/jk_latch.sv
// Array of WIDTH independent, edge-triggered JK cells sharing one enable.
// Synchronous active-low reset loads RESET_VAL and overrides every request.
module jk_latch #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic        clk,
    input logic        rst_n,
    jk_latch_if.slave  bus
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Next state is built only from the registered value, so J=K=1 flips once per edge.
    always_comb begin
        q_d = q_q;
        if (bus.en) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                unique case ({bus.J[i], bus.K[i]})
                    2'b00:   q_d[i] = q_q[i];
                    2'b01:   q_d[i] = 1'b0;
                    2'b10:   q_d[i] = 1'b1;
                    2'b11:   q_d[i] = ~q_q[i];
                    default: q_d[i] = q_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.Q  = q_q;
    assign bus.Qn = ~q_q;

endmodule

// File: tb/tb_jk_latch.sv
// Directed bench for jk_latch: single-bit cells with both reset values and a 4-bit array.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_jk_latch;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    jk_latch_if #(.WIDTH(1)) bus_a ();
    jk_latch_if #(.WIDTH(1)) bus_b ();
    jk_latch_if #(.WIDTH(4)) bus_c ();

    jk_latch #(.WIDTH(1), .RESET_VAL(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    jk_latch #(.WIDTH(1), .RESET_VAL(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    jk_latch #(.WIDTH(4), .RESET_VAL(4'b0000)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    typedef struct packed {
        logic rst_n;
        logic en;
        logic j;
        logic k;
        logic qa;   // expected Q for RESET_VAL=0
        logic qb;   // expected Q for RESET_VAL=1
    } vec1_t;

    typedef struct packed {
        logic       rst_n;
        logic       en;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] q;
    } vec4_t;

    vec1_t v1[19];
    vec4_t v4[8];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_a_b(input string name, input logic qa, input logic qb);
        logic na;
        logic nb;
        na = ~qa;
        nb = ~qb;
        check({name, " a.Q"},  {3'b000, bus_a.Q},  {3'b000, qa});
        check({name, " a.Qn"}, {3'b000, bus_a.Qn}, {3'b000, na});
        check({name, " b.Q"},  {3'b000, bus_b.Q},  {3'b000, qb});
        check({name, " b.Qn"}, {3'b000, bus_b.Qn}, {3'b000, nb});
    endtask

    task automatic drive1(input logic r, input logic e, input logic j, input logic k);
        rst_n    = r;
        bus_a.en = e;  bus_a.J = j;  bus_a.K = k;
        bus_b.en = e;  bus_b.J = j;  bus_b.K = k;
    endtask

    initial begin
        //            rst   en    J     K     qa    qb
        v1[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};  // reset beats toggle
        v1[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        v1[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        v1[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        v1[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        v1[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        v1[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        v1[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        v1[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};  // disabled: hold
        v1[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        v1[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        v1[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        v1[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        v1[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        v1[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        v1[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        v1[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        v1[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};  // toggle applied to reset value
        v1[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        //            rst   en    J        K        Q
        v4[0]  = '{1'b0, 1'b1, 4'b1111, 4'b1111, 4'b0000};
        v4[1]  = '{1'b1, 1'b1, 4'b1010, 4'b0110, 4'b1010};  // set/clear/toggle/hold per bit
        v4[2]  = '{1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0101};
        v4[3]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0101};
        v4[4]  = '{1'b1, 1'b1, 4'b0011, 4'b1100, 4'b0011};
        v4[5]  = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1111};
        v4[6]  = '{1'b1, 1'b1, 4'b0000, 4'b0001, 4'b1110};
        v4[7]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000};

        rst_n    = 1'b0;
        bus_c.en = 1'b0;
        bus_c.J  = '0;
        bus_c.K  = '0;
        drive1(1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive1(v1[i].rst_n, v1[i].en, v1[i].j, v1[i].k);
            @(posedge clk);
            #1;
            check_a_b($sformatf("w1 vec%0d", i), v1[i].qa, v1[i].qb);
        end

        // Glitches on J/K/en between edges must not matter; a=0, b=1 here.
        @(negedge clk);
        drive1(1'b1, 1'b1, 1'b1, 1'b1);
        #2 drive1(1'b1, 1'b0, 1'b0, 1'b1);
        #1 drive1(1'b1, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_a_b("glitch pre-edge", 1'b1, 1'b0);
        drive1(1'b1, 1'b1, 1'b0, 1'b1);
        #2;
        check_a_b("glitch post-edge", 1'b1, 1'b0);
        drive1(1'b1, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_a_b("toggle after glitch", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_a_b("toggle held", 1'b1, 1'b0);

        // Reset asserted mid-cycle waits for the next rising edge.
        rst_n = 1'b0;
        #2;
        check_a_b("reset mid-cycle", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_a_b("reset at edge", 1'b0, 1'b1);

        drive1(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [3:0] nq;
            @(negedge clk);
            rst_n    = v4[i].rst_n;
            bus_c.en = v4[i].en;
            bus_c.J  = v4[i].j;
            bus_c.K  = v4[i].k;
            @(posedge clk);
            #1;
            nq = ~v4[i].q;
            check($sformatf("w4 vec%0d Q", i),  bus_c.Q,  v4[i].q);
            check($sformatf("w4 vec%0d Qn", i), bus_c.Qn, nq);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
